ps2_rx: RTL
===========

PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clock32 and reset as elsewhere in the codebase.
REQ-002 clock32  in  1  system clock, 32 MHz; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on the rising edge of clock32.
REQ-004 ps2Ck  in  1  raw PS/2 clock line from the pad, asynchronous.
REQ-005 ps2D  in  1  raw PS/2 data line from the pad, asynchronous.
REQ-006 strb  out  1  one-cycle pulse; make/code/ext are valid in that cycle; feeds the keyboard strb input.
REQ-007 make  out  1  1 = key press, 0 = key release (F0 prefix seen); held until the next strb.
REQ-008 code  out  8  scan code byte; held until the next strb.
REQ-009 ext  out  1  1 = E0 prefix preceded the code; held until the next strb.
REQ-010 err  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-011 ps2Ck and ps2D SHALL each pass through a 2-flop synchroniser before any use.
REQ-012 The filtered clock SHALL change state only after 16 consecutive identical synchronised ps2Ck samples; its reset value is 1.
REQ-013 A falling edge of the filtered clock (fall) SHALL sample the synchronised ps2D; no other event advances the frame.
REQ-014 FSM states: IDLE, DATA, PARITY, STOP; reset state is IDLE.
REQ-015 IDLE: on fall with data=0, go to DATA with bit count 0; on fall with data=1 (false start), stay in IDLE with no err.
REQ-016 DATA: on each fall, shift the data bit into the byte LSB-first; after the 8th bit go to PARITY.
REQ-017 PARITY: on fall, store the bit and go to STOP; odd parity is required (XOR of 8 data bits and parity bit = 1).
REQ-018 STOP: on fall, if stop=1 and parity is good, accept the byte; otherwise pulse err, clear the E0 and F0 flags, and drop the byte; go to IDLE in either case.
REQ-019 When the accepted byte is E0: set the E0 flag with no strb.
REQ-020 When the accepted byte is F0: set the F0 flag with no strb.
REQ-021 Any other accepted byte (including E1, AA, FA, FE) SHALL produce in the next cycle: strb=1, code=byte, make=~F0flag, ext=E0flag; both flags clear in the same cycle.
REQ-022 Latency: strb asserts exactly 1 clock32 cycle after the cycle in which the STOP fall is detected.
REQ-023 The E0 and F0 flags are independent; either prefix order (E0 F0 or F0 E0) yields ext=1, make=0.
REQ-024 strb and err SHALL never assert in the same cycle; each is high for exactly one cycle per event.
REQ-025 Output registers make, code and ext SHALL change only in a strb cycle.

Reset
REQ-026 On reset: FSM=IDLE, bit count=0, byte=00, E0 and F0 flags=0, filter counters=0, filtered clock=1, strb=0, err=0, make=0, code=00, ext=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame without strb or err; reception restarts at the next start bit after release.
REQ-028 Reset SHALL take priority over a simultaneous strb, err or fall event.

Configuration
REQ-029 Macro PS2_RX_WATCHDOG_EN, when defined, SHALL add a 17-bit watchdog cleared on every fall and held at 0 in IDLE.
REQ-030 With PS2_RX_WATCHDOG_EN defined, if the watchdog reaches 2^17-1 (about 4.1 ms) outside IDLE: pulse err, clear the flags, go to IDLE.
REQ-031 Without PS2_RX_WATCHDOG_EN, no watchdog logic SHALL exist, and a truncated frame stalls until further falls complete it.

Verification
REQ-032 Frame 0x1C (parity 0, stop 1) at 12.5 kHz -> one strb, code=1C, make=1, ext=0, err never asserted.
REQ-033 Bytes F0 then 1C -> no strb after F0; strb after 1C with code=1C, make=0, ext=0; a following 1C gives make=1.
REQ-034 Bytes E0, F0, 75 -> single strb with code=75, make=0, ext=1; flags cleared afterwards.
REQ-035 Frame 0x1C with parity forced to 1 -> err pulses 1 cycle, no strb, code still holds its previous value; next valid 0x2A -> strb, code=2A.
REQ-036 Glitches on ps2Ck of 8 clock32 cycles inserted mid-bit -> ignored, byte received correctly; reset pulsed after 4 data bits -> no strb/err, next frame 0x5A -> code=5A.
REQ-037 With PS2_RX_WATCHDOG_EN: stop after 5 bits, idle 5 ms -> err pulse ≈131071 cycles after last fall; next frame 0x29 -> code=29. Without the macro: no err.

Source files
------------

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 keyboard receiver that turns raw pad lines into decoded scan-code strobes.
// Ports: clock32/reset (32 MHz clock, sync active-high reset), ps2Ck/ps2D (async pad lines),
//        strb (1-cycle code valid), make/code/ext (held until next strb), err (1-cycle error pulse).
// Option: define PS2_RX_WATCHDOG_EN to add a ~4.1 ms mid-frame timeout.
module ps2_rx (
    input  logic       clock32,
    input  logic       reset,
    input  logic       ps2Ck,
    input  logic       ps2D,
    output logic       strb,
    output logic       make,
    output logic [7:0] code,
    output logic       ext,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t     state;
    logic [1:0] ck_s, d_s;
    logic [3:0] cnt;
    logic       ck_f, par, e0, f0, fall;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
`ifdef PS2_RX_WATCHDOG_EN
    logic [16:0] wd;
`endif
    // the 16th consecutive low sample while the filtered clock is high is the falling edge
    assign fall = ck_f & ~ck_s[1] & (cnt == 4'd15);
    always_ff @(posedge clock32) begin
        if (reset) begin
            ck_s    <= 2'b11;
            d_s     <= 2'b11;
            cnt     <= '0;
            ck_f    <= 1'b1;
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            e0      <= 1'b0;
            f0      <= 1'b0;
            strb    <= 1'b0;
            err     <= 1'b0;
            make    <= 1'b0;
            code    <= '0;
            ext     <= 1'b0;
`ifdef PS2_RX_WATCHDOG_EN
            wd      <= '0;
`endif
        end else begin
            ck_s <= {ck_s[0], ps2Ck};
            d_s  <= {d_s[0], ps2D};
            strb <= 1'b0;
            err  <= 1'b0;
            if (ck_s[1] == ck_f) cnt <= '0;
            else if (cnt == 4'd15) begin
                ck_f <= ck_s[1];
                cnt  <= '0;
            end else cnt <= cnt + 4'd1;
            if (fall) begin
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
                        state   <= d_s[1] ? IDLE : DATA;
                    end
                    DATA: begin
                        shreg   <= {d_s[1], shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        state   <= (bit_cnt == 3'd7) ? PARITY : DATA;
                    end
                    PARITY: begin
                        par   <= d_s[1];
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (d_s[1] && (^{shreg, par})) begin
                            if (shreg == 8'hE0) e0 <= 1'b1;
                            else if (shreg == 8'hF0) f0 <= 1'b1;
                            else begin
                                strb <= 1'b1;
                                code <= shreg;
                                make <= ~f0;
                                ext  <= e0;
                                e0   <= 1'b0;
                                f0   <= 1'b0;
                            end
                        end else begin
                            err <= 1'b1;
                            e0  <= 1'b0;
                            f0  <= 1'b0;
                        end
                    end
                endcase
            end
`ifdef PS2_RX_WATCHDOG_EN
            // a fall wins over an expiring count, so strb and err cannot coincide
            if (state == IDLE || fall) wd <= '0;
            else if (&wd) begin
                wd    <= '0;
                err   <= 1'b1;
                e0    <= 1'b0;
                f0    <= 1'b0;
                state <= IDLE;
            end else wd <= wd + 17'd1;
`endif
        end
    end
endmodule
